// File: rtl/vga_linebuf_ctrl_if.sv
// Source pixel handshake and 1R1W line-RAM port bundle for vga_linebuf_ctrl.
// The controller uses the master view; the pixel source and RAM model use the slave view.
interface vga_linebuf_ctrl_if #(
    parameter int HW = 10,
    parameter int DW = 12
);
    logic          src_req;
    logic          src_sof;
    logic          src_vld;
    logic          src_rdy;
    logic [DW-1:0] src_data;
    logic          ram_we;
    logic [HW:0]   ram_addr_w;
    logic [DW-1:0] ram_din;
    logic [HW:0]   ram_addr_r;

    modport master (
        output src_req, src_sof, src_rdy, ram_we, ram_addr_w, ram_din, ram_addr_r,
        input  src_vld, src_data
    );

    modport slave (
        input  src_req, src_sof, src_rdy, ram_we, ram_addr_w, ram_din, ram_addr_r,
        output src_vld, src_data
    );
endinterface

// File: rtl/vga_linebuf_ctrl.sv
// Ping-pong line-buffer controller: fills one RAM bank from the pixel source
// while the display reads the other, swapping banks on each line_sync.
//
// state | meaning
// IDLE  | frame finished (or after reset); waits for frame_start
// REQ   | one-cycle request for the next line from the source
// FILL  | accepting pixels into the fill bank
// DONE  | line complete; waits for line_sync to swap banks
module vga_linebuf_ctrl #(
    parameter int HW        = 10,
    parameter int DW        = 12,
    parameter int H_DISPLAY = 640,
    parameter int V_DISPLAY = 480
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic                  line_sync,
    input  logic [HW-1:0]         rd_x,
    output logic                  underrun,
    vga_linebuf_ctrl_if.master    bus
);
    localparam int LW = $clog2(V_DISPLAY + 1);
    localparam logic [HW-1:0] W_LAST  = HW'(H_DISPLAY - 1);
    localparam logic [LW-1:0] L_LINES = LW'(V_DISPLAY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FILL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic          fill_bank;
    logic          sof_flag;
    logic [HW-1:0] wcnt;
    logic [LW-1:0] lcnt;
    logic          handshake;

    assign handshake = (state == S_FILL) && bus.src_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // frame_start overrides everything, including a coincident line_sync.
    always_comb begin
        state_nxt = state;
        if (frame_start) begin
            state_nxt = S_REQ;
        end else begin
            case (state)
                S_IDLE: state_nxt = S_IDLE;
                S_REQ:  state_nxt = S_FILL;
                S_FILL: if (handshake && (wcnt == W_LAST)) state_nxt = S_DONE;
                S_DONE: if (line_sync) state_nxt = (lcnt < L_LINES) ? S_REQ : S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_bank <= 1'b0;
            sof_flag  <= 1'b0;
            wcnt      <= '0;
            lcnt      <= '0;
            underrun  <= 1'b0;
        end else begin
            underrun <= line_sync && !frame_start && ((state == S_REQ) || (state == S_FILL));
            if (frame_start) begin
                wcnt     <= '0;
                lcnt     <= '0;
                sof_flag <= 1'b1;
            end else begin
                case (state)
                    S_REQ: begin
                        lcnt     <= lcnt + 1'b1;
                        wcnt     <= '0;
                        sof_flag <= 1'b0;
                    end
                    S_FILL: if (handshake) wcnt <= wcnt + 1'b1;
                    S_DONE: if (line_sync) fill_bank <= ~fill_bank;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        bus.src_req    = 1'b0;
        bus.src_sof    = 1'b0;
        bus.src_rdy    = 1'b0;
        bus.ram_we     = 1'b0;
        bus.ram_addr_w = {fill_bank, wcnt};
        bus.ram_din    = bus.src_data;
        bus.ram_addr_r = {~fill_bank, rd_x};
        case (state)
            S_REQ: begin
                bus.src_req = 1'b1;
                bus.src_sof = sof_flag;
            end
            S_FILL: begin
                bus.src_rdy = 1'b1;
                bus.ram_we  = bus.src_vld;
            end
            default: ;
        endcase
    end
endmodule
